// File: rtl/iob_cache_axi_ram_responder_if.sv
// AXI4 bus bundle between the cache back-end (master) and the RAM responder (slave).
interface iob_cache_axi_ram_responder_if #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ADDR_W = 14,
  parameter int AXI_DATA_W = 32
);
  // write address channel
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [AXI_ADDR_W-1:0]   s_axi_awaddr;
  logic [AXI_ID_W-1:0]     s_axi_awid;
  logic [AXI_LEN_W-1:0]    s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  // write data channel
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [AXI_DATA_W-1:0]   s_axi_wdata;
  logic [AXI_DATA_W/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  // write response channel
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [AXI_ID_W-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;
  // read address channel
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [AXI_ADDR_W-1:0]   s_axi_araddr;
  logic [AXI_ID_W-1:0]     s_axi_arid;
  logic [AXI_LEN_W-1:0]    s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  // read data channel
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic [AXI_DATA_W-1:0]   s_axi_rdata;
  logic [AXI_ID_W-1:0]     s_axi_rid;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    input  s_axi_awready,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    input  s_axi_wready,
    input  s_axi_bvalid, s_axi_bid, s_axi_bresp,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    output s_axi_awready,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    output s_axi_wready,
    output s_axi_bvalid, s_axi_bid, s_axi_bresp,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast,
    input  s_axi_rready
  );
endinterface

// File: rtl/iob_cache_axi_ram_responder.sv
// AXI4 slave with an internal word-addressed RAM. Independent read and write
// burst engines (INCR only; other burst types run as INCR but answer SLVERR).
module iob_cache_axi_ram_responder #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ADDR_W = 14,
  parameter int AXI_DATA_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  iob_cache_axi_ram_responder_if.slave axi
);

  localparam int OFFSET_W   = $clog2(AXI_DATA_W / 8);
  localparam int MEM_ADDR_W = AXI_ADDR_W - OFFSET_W;
  localparam int STRB_W     = AXI_DATA_W / 8;
  localparam int DEPTH      = 2 ** MEM_ADDR_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] FULL_SIZE   = 3'(OFFSET_W);

  localparam logic [MEM_ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [AXI_LEN_W-1:0]  LEN_ONE  = 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_SEND  = 2'd2;

  // ---------------------------------------------------------------------------
  // storage
  // ---------------------------------------------------------------------------
  logic [AXI_DATA_W-1:0] mem [0:DEPTH-1];

  // byte offset bits inside a word carry no information for full-width beats
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.s_axi_awaddr[OFFSET_W-1:0], axi.s_axi_araddr[OFFSET_W-1:0]};

  // ---------------------------------------------------------------------------
  // write path state
  // ---------------------------------------------------------------------------
  logic [1:0]            w_state_reg, w_state_next;
  logic [MEM_ADDR_W-1:0] w_addr_reg;
  logic [AXI_ID_W-1:0]   w_id_reg;
  logic [AXI_LEN_W-1:0]  w_len_reg;
  logic [AXI_LEN_W-1:0]  w_cnt_reg;
  logic                  w_bad_reg;
  logic                  w_err_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;

  logic aw_hs, w_hs, b_hs;
  logic w_last_beat;
  logic w_last_mismatch;
  logic aw_bad;

  assign aw_hs           = axi.s_axi_awvalid & awready_reg;
  assign w_hs            = axi.s_axi_wvalid & wready_reg;
  assign b_hs            = bvalid_reg & axi.s_axi_bready;
  assign w_last_beat     = (w_cnt_reg == w_len_reg);
  assign w_last_mismatch = (axi.s_axi_wlast != w_last_beat);
  assign aw_bad          = (axi.s_axi_awburst != BURST_INCR) || (axi.s_axi_awsize != FULL_SIZE);

  // write FSM next-state: accept address, take awlen+1 beats, then respond
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if (aw_hs) w_state_next = W_DATA;
      W_DATA: if (w_hs && w_last_beat) w_state_next = W_RESP;
      W_RESP: if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // write FSM registers; ready/valid outputs are decoded from the next state so
  // they are registered and read as 0 throughout reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_reg <= W_IDLE;
      w_addr_reg  <= '0;
      w_id_reg    <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_bad_reg   <= 1'b0;
      w_err_reg   <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      w_state_reg <= w_state_next;
      awready_reg <= (w_state_next == W_IDLE);
      wready_reg  <= (w_state_next == W_DATA);
      bvalid_reg  <= (w_state_next == W_RESP);
      if (aw_hs) begin
        w_addr_reg <= axi.s_axi_awaddr[AXI_ADDR_W-1:OFFSET_W];
        w_id_reg   <= axi.s_axi_awid;
        w_len_reg  <= axi.s_axi_awlen;
        w_cnt_reg  <= '0;
        w_bad_reg  <= aw_bad;
        w_err_reg  <= 1'b0;
      end
      if (w_hs) begin
        w_addr_reg <= w_addr_reg + ADDR_ONE;
        w_cnt_reg  <= w_cnt_reg + LEN_ONE;
        if (w_last_mismatch) begin
          w_err_reg <= 1'b1;
        end
        // response is resolved on the final beat so bresp is ready with bvalid
        if (w_last_beat) begin
          bresp_reg <= (w_bad_reg || w_err_reg || w_last_mismatch) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // RAM write port with per-byte enables; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_hs && !rst_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.s_axi_wstrb[b]) begin
          mem[w_addr_reg][b*8 +: 8] <= axi.s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign axi.s_axi_awready = awready_reg;
  assign axi.s_axi_wready  = wready_reg;
  assign axi.s_axi_bvalid  = bvalid_reg;
  assign axi.s_axi_bresp   = bresp_reg;
  assign axi.s_axi_bid     = w_id_reg;

  // ---------------------------------------------------------------------------
  // read path state
  // ---------------------------------------------------------------------------
  logic [1:0]            r_state_reg, r_state_next;
  logic [MEM_ADDR_W-1:0] r_addr_reg;
  logic [AXI_ID_W-1:0]   r_id_reg;
  logic [AXI_LEN_W-1:0]  r_len_reg;
  logic [AXI_LEN_W-1:0]  r_cnt_reg;
  logic [1:0]            rresp_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic                  rlast_reg;
  logic [AXI_DATA_W-1:0] rdata_reg;

  logic ar_hs, r_hs;
  logic ar_bad;

  assign ar_hs  = axi.s_axi_arvalid & arready_reg;
  assign r_hs   = rvalid_reg & axi.s_axi_rready;
  assign ar_bad = (axi.s_axi_arburst != BURST_INCR) || (axi.s_axi_arsize != FULL_SIZE);

  // read FSM next-state: one fetch cycle for the synchronous RAM, then present
  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_FETCH;
      R_FETCH: r_state_next = R_SEND;
      R_SEND:  if (r_hs) r_state_next = rlast_reg ? R_IDLE : R_FETCH;
      default: r_state_next = R_IDLE;
    endcase
  end

  // read FSM registers; address/count advance only after a beat is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_id_reg    <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      arready_reg <= (r_state_next == R_IDLE);
      rvalid_reg  <= (r_state_next == R_SEND);
      if (ar_hs) begin
        r_addr_reg <= axi.s_axi_araddr[AXI_ADDR_W-1:OFFSET_W];
        r_id_reg   <= axi.s_axi_arid;
        r_len_reg  <= axi.s_axi_arlen;
        r_cnt_reg  <= '0;
        rresp_reg  <= ar_bad ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_state_reg == R_FETCH) begin
        rlast_reg <= (r_cnt_reg == r_len_reg);
      end
      if (r_hs) begin
        if (rlast_reg) begin
          rlast_reg <= 1'b0;
        end else begin
          r_addr_reg <= r_addr_reg + ADDR_ONE;
          r_cnt_reg  <= r_cnt_reg + LEN_ONE;
        end
      end
    end
  end

  // RAM read port: registered output captured in the fetch cycle and held
  // through the send phase, so rdata stays stable under backpressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_reg <= '0;
    end else if (r_state_reg == R_FETCH) begin
      rdata_reg <= mem[r_addr_reg];
    end
  end

  assign axi.s_axi_arready = arready_reg;
  assign axi.s_axi_rvalid  = rvalid_reg;
  assign axi.s_axi_rdata   = rdata_reg;
  assign axi.s_axi_rid     = r_id_reg;
  assign axi.s_axi_rresp   = rresp_reg;
  assign axi.s_axi_rlast   = rlast_reg;

endmodule

// File: tb/tb_iob_cache_axi_ram_responder.sv
// Directed bench for the AXI RAM responder with a reference RAM model and a
// read-beat scoreboard.
module tb_iob_cache_axi_ram_responder;

  localparam int ID_W   = 1;
  localparam int LEN_W  = 8;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iob_cache_axi_ram_responder_if #(
    .AXI_ID_W(ID_W), .AXI_LEN_W(LEN_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W)
  ) axi ();

  iob_cache_axi_ram_responder #(
    .AXI_ID_W(ID_W), .AXI_LEN_W(LEN_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .axi(axi)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
    logic            last;
    logic [31:0]     data;
  } rexp_t;

  rexp_t       exp_q[$];
  logic [31:0] model [0:WORDS-1];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [13:0] addr, input logic [7:0] len, input logic id,
                         input logic [1:0] burst, input logic [2:0] size);
    int t = 0;
    axi.s_axi_awaddr  = addr;
    axi.s_axi_awlen   = len;
    axi.s_axi_awid    = id;
    axi.s_axi_awburst = burst;
    axi.s_axi_awsize  = size;
    axi.s_axi_awvalid = 1'b1;
    while (axi.s_axi_awready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("aw_wait", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    axi.s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input int word);
    int t = 0;
    axi.s_axi_wdata  = data;
    axi.s_axi_wstrb  = strb;
    axi.s_axi_wlast  = last;
    axi.s_axi_wvalid = 1'b1;
    while (axi.s_axi_wready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("w_wait", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    axi.s_axi_wvalid = 1'b0;
    axi.s_axi_wlast  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[word][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic b_check(input logic id, input logic [1:0] resp);
    int t = 0;
    axi.s_axi_bready = 1'b1;
    while (axi.s_axi_bvalid !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("b_wait", 64'(t < 100), 64'd1);
    check("bresp", 64'(axi.s_axi_bresp), 64'(resp));
    check("bid", 64'(axi.s_axi_bid), 64'(id));
    @(posedge clk); #1;
    axi.s_axi_bready = 1'b0;
    check("bvalid_drop", 64'(axi.s_axi_bvalid), 64'd0);
    check("awready_after_b", 64'(axi.s_axi_awready), 64'd1);
  endtask

  // full write burst; wlast is raised on beat wlast_beat (len for a legal burst)
  task automatic do_write(input logic [13:0] addr, input logic [7:0] len, input logic id,
                          input logic [31:0] base, input logic [3:0] strb,
                          input logic [1:0] burst, input logic [2:0] size, input int wlast_beat);
    logic [1:0] resp;
    resp = (burst != 2'b01 || size != 3'd2 || wlast_beat != int'(len)) ? 2'b10 : 2'b00;
    aw_send(addr, len, id, burst, size);
    check("wready_lat", 64'(axi.s_axi_wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      w_beat(base + 32'(i), strb, (i == wlast_beat), (int'(addr >> 2) + i) % WORDS);
    end
    check("bvalid_lat", 64'(axi.s_axi_bvalid), 64'd1);
    b_check(id, resp);
  endtask

  // read burst; expectations queued from the model, popped on R handshakes
  task automatic do_read(input logic [13:0] addr, input logic [7:0] len, input logic id,
                         input logic [2:0] size, input logic [1:0] burst, input bit bp);
    int          t = 0;
    int          k = 0;
    int          first = -1;
    int          last_hs = -1;
    bit          held = 0;
    logic [32:0] hval;
    logic        rdy;
    logic [4:0]  pat = 5'b10010;
    logic [1:0]  resp;
    rexp_t       e;
    resp = (burst != 2'b01 || size != 3'd2) ? 2'b10 : 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.resp = resp;
      e.last = (i == int'(len));
      e.data = model[(int'(addr >> 2) + i) % WORDS];
      exp_q.push_back(e);
    end
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = len;
    axi.s_axi_arid    = id;
    axi.s_axi_arsize  = size;
    axi.s_axi_arburst = burst;
    axi.s_axi_arvalid = 1'b1;
    while (axi.s_axi_arready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("ar_wait", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b0;
    check("rvalid_early", 64'(axi.s_axi_rvalid), 64'd0);
    while (exp_q.size() > 0 && k < 300) begin
      rdy = bp ? pat[k % 5] : 1'b1;
      axi.s_axi_rready = rdy;
      if (held) begin
        check("r_hold_valid", 64'(axi.s_axi_rvalid), 64'd1);
        check("r_hold_data", 64'({axi.s_axi_rlast, axi.s_axi_rdata}), 64'(hval));
      end
      held = 0;
      if (axi.s_axi_rvalid === 1'b1) begin
        if (first < 0) first = k;
        if (rdy) begin
          e = exp_q.pop_front();
          check("rbeat", 64'({axi.s_axi_rid, axi.s_axi_rresp, axi.s_axi_rlast, axi.s_axi_rdata}),
                64'(e));
          if (last_hs >= 0) check("r_spacing", 64'((k - last_hs) >= 2), 64'd1);
          last_hs = k;
        end else begin
          held = 1;
          hval = {axi.s_axi_rlast, axi.s_axi_rdata};
        end
      end
      @(posedge clk); #1;
      k++;
    end
    axi.s_axi_rready = 1'b0;
    check("r_wait", 64'(k < 300), 64'd1);
    check("r_first_lat", 64'(first), 64'd1);
    check("arready_after_r", 64'(axi.s_axi_arready), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    axi.s_axi_awvalid = 0; axi.s_axi_awaddr = 0; axi.s_axi_awid = 0; axi.s_axi_awlen = 0;
    axi.s_axi_awsize = 0; axi.s_axi_awburst = 0;
    axi.s_axi_wvalid = 0; axi.s_axi_wdata = 0; axi.s_axi_wstrb = 0; axi.s_axi_wlast = 0;
    axi.s_axi_bready = 0;
    axi.s_axi_arvalid = 0; axi.s_axi_araddr = 0; axi.s_axi_arid = 0; axi.s_axi_arlen = 0;
    axi.s_axi_arsize = 0; axi.s_axi_arburst = 0;
    axi.s_axi_rready = 0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_valid", 64'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid,
                                  axi.s_axi_arready, axi.s_axi_rvalid, axi.s_axi_rlast}), 64'd0);
    check("rst_resp_id", 64'({axi.s_axi_bresp, axi.s_axi_rresp, axi.s_axi_bid, axi.s_axi_rid}), 64'd0);
    check("rst_rdata", 64'(axi.s_axi_rdata), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("awready_rel", 64'(axi.s_axi_awready), 64'd1);
    check("arready_rel", 64'(axi.s_axi_arready), 64'd1);
    $display("reset checked");

    // basic write burst and readback
    do_write(14'h010, 8'd3, 1'b1, 32'hA0, 4'hF, 2'b01, 3'd2, 3);
    $display("write 0x10 len3 done");
    do_read(14'h010, 8'd3, 1'b1, 3'd2, 2'b01, 1'b0);
    $display("read 0x10 len3 done");

    // byte strobes
    do_write(14'h000, 8'd0, 1'b0, 32'h11223344, 4'hF, 2'b01, 3'd2, 0);
    do_write(14'h000, 8'd0, 1'b0, 32'hAABBCCDD, 4'b0101, 2'b01, 3'd2, 0);
    check("strobe_model", 64'(model[0]), 64'h11BB33DD);
    do_read(14'h000, 8'd0, 1'b0, 3'd2, 2'b01, 1'b0);
    $display("byte strobe write/read done");

    // backpressure read
    do_read(14'h010, 8'd3, 1'b0, 3'd2, 2'b01, 1'b1);
    $display("backpressure read done");

    // errors: FIXED burst type, early wlast, narrow read size
    do_write(14'h040, 8'd1, 1'b0, 32'hB0, 4'hF, 2'b00, 3'd2, 1);
    do_read(14'h040, 8'd1, 1'b0, 3'd2, 2'b01, 1'b0);
    $display("bad awburst done");
    do_write(14'h080, 8'd3, 1'b1, 32'hC0, 4'hF, 2'b01, 3'd2, 1);
    $display("early wlast done");
    do_read(14'h080, 8'd3, 1'b1, 3'd1, 2'b01, 1'b0);
    $display("narrow arsize done");

    // address wrap at the top of RAM
    do_write(14'h3FFC, 8'd1, 1'b1, 32'hD0, 4'hF, 2'b01, 3'd2, 1);
    do_read(14'h3FFC, 8'd1, 1'b1, 3'd2, 2'b01, 1'b0);
    do_read(14'h0000, 8'd0, 1'b0, 3'd2, 2'b01, 1'b0);
    $display("wrap done");

    // concurrent read and write on different words
    fork
      do_write(14'h200, 8'd3, 1'b1, 32'hE0, 4'hF, 2'b01, 3'd2, 3);
      do_read(14'h010, 8'd3, 1'b0, 3'd2, 2'b01, 1'b0);
    join
    do_read(14'h200, 8'd3, 1'b1, 3'd2, 2'b01, 1'b0);
    $display("concurrent read/write done");

    // reset in the middle of a write burst
    aw_send(14'h300, 8'd3, 1'b0, 2'b01, 3'd2);
    w_beat(32'hF0, 4'hF, 1'b0, 14'h300 >> 2);
    w_beat(32'hF1, 4'hF, 1'b0, (14'h300 >> 2) + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outs", 64'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid,
                               axi.s_axi_arready, axi.s_axi_rvalid}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("awready_mid_rel", 64'(axi.s_axi_awready), 64'd1);
    do_write(14'h340, 8'd3, 1'b1, 32'h55, 4'hF, 2'b01, 3'd2, 3);
    do_read(14'h340, 8'd3, 1'b1, 3'd2, 2'b01, 1'b0);
    do_read(14'h300, 8'd1, 1'b0, 3'd2, 2'b01, 1'b0);
    $display("reset mid-burst done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_cache_axi_ram_responder.md
# iob_cache_axi_ram_responder

AXI4 slave (responder) with internal word-addressed RAM, serving the cache back-end's AXI4 master read and write channels. It accepts INCR bursts on independent read and write paths and returns read beats and write responses. It is the memory-side model and synthesizable scratch memory used to close the cache back-end loop in simulation and in small FPGA systems.

## Interface
- AXI_ID_W, 1, ID width
- AXI_LEN_W, 8, burst length field width
- AXI_ADDR_W, 14, byte address width
- AXI_DATA_W, 32, data width (power of two, ≥8)
- MEM_ADDR_W, AXI_ADDR_W - log2(AXI_DATA_W/8), word address width; RAM depth 2**MEM_ADDR_W
- clk_i  in  1  clock. One clock; all logic on its rising edge.
- rst_i  in  1  reset. Synchronous and active-high.
- s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
- s_axi_awaddr  in  AXI_ADDR_W  burst start byte address
- s_axi_awid  in  AXI_ID_W; s_axi_awlen  in  AXI_LEN_W (beats-1); s_axi_awsize  in  3; s_axi_awburst  in  2
- s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
- s_axi_wdata  in  AXI_DATA_W; s_axi_wstrb  in  AXI_DATA_W/8; s_axi_wlast  in  1
- s_axi_bvalid / s_axi_bready  out/in  1; s_axi_bid  out  AXI_ID_W; s_axi_bresp  out  2
- s_axi_arvalid / s_axi_arready  in/out  1; s_axi_araddr  in  AXI_ADDR_W
- s_axi_arid  in  AXI_ID_W; s_axi_arlen  in  AXI_LEN_W; s_axi_arsize  in  3; s_axi_arburst  in  2
- s_axi_rvalid / s_axi_rready  out/in  1; s_axi_rdata  out  AXI_DATA_W; s_axi_rid  out  AXI_ID_W; s_axi_rresp  out  2; s_axi_rlast  out  1

## Operation
- RAM: one write port, one read port (synchronous read, 1-cycle latency). Same-word read and write in the same cycle: read returns old data.
- Word address = byte address >> log2(AXI_DATA_W/8); low bits ignored. Increment per beat is +1 word, wrapping modulo 2**MEM_ADDR_W.
- Burst check: "bad" if burst != 2'b01 (INCR) or size != log2(AXI_DATA_W/8). Bad bursts are still executed as full-width INCR. The response is SLVERR (2'b10), else OKAY (2'b00).
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch word address, awid, awlen, and the bad flag; clear the beat counter.
  - W_DATA: wready=1. Each W handshake writes wdata under wstrb (byte enables), then increments address and counter. The beat where counter==awlen is last, and the FSM goes to W_RESP. The burst always ends after awlen+1 beats regardless of wlast. wlast high on a non-final beat, or low on the final beat, sets the error flag.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR if bad or wlast error, else OKAY. Hold until bready, then W_IDLE.
- Read FSM R_IDLE -> R_FETCH -> R_SEND:
  - R_IDLE: arready=1. On AR handshake, latch address, id, len, and the bad flag.
  - R_FETCH: issue RAM read at the current address.
  - R_SEND: rvalid=1; rdata, rid, rresp and rlast (counter==arlen) are stable until rready. On handshake, if last go to R_IDLE, else increment address/counter and go to R_FETCH.
- Read and write FSMs are fully independent; both may be active simultaneously.
- Reset:
  - rst_i high forces both FSMs idle, clears counters and flags, and drives all of these to 0 in the cycle after the rst_i edge: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata.
  - awready and arready rise on the first cycle after rst_i deasserts.
  - Reset mid-burst abandons the burst; RAM contents are not cleared.

## Timing
- AW handshake at cycle T -> wready from T+1; a beat handshaked at cycle C is written at edge C (visible to reads issued at C+1).
- Final W beat at L -> bvalid at L+1; B handshake at B -> awready at B+1.
- AR handshake at T -> rvalid with beat 0 at T+2. R handshake at S -> next beat rvalid at S+2, so max read throughput is 1 beat / 2 cycles.
- Last R handshake at S -> arready at S+1.
- Outputs are stable while valid is high and ready is low (AXI rule); inputs are sampled only on the handshake cycle.

## Test plan
- Write burst: awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF, wlast on beat 3, bready=1 -> bvalid 1 cycle after beat 3 with bresp=0, bid=awid; read back via arlen=3 -> rdata 0xA0..0xA3, rlast only on beat 3, rresp=0.
- Byte strobes: word 0 preloaded with 0x11223344, single write 0xAABBCCDD with wstrb=0b0101 -> readback 0x11BB33DD.
- Backpressure: 4-beat read with rready toggling 0,1,0,0,1… -> rdata/rlast are held while rready=0, no beat is lost or duplicated, and beat spacing is ≥2 cycles.
- Errors: awburst=2'b00 -> data still written INCR, bresp=2'b10. wlast asserted on beat 1 of awlen=3 -> all 4 beats written, bresp=2'b10. arsize=1 -> all beats have rresp=2'b10.
- Wrap and concurrency: write a burst starting at the last RAM word, len=1 -> the second beat lands at word 0. Concurrent AR and AW to different words -> both complete with correct data.
- Reset mid-write-burst after 2 of 4 beats -> all valids/readies are 0 during reset, awready=1 the cycle after release, a new burst completes normally, and the 2 written words persist.
